// File: rtl/set_cmd_scheduler.sv
// set_cmd_scheduler: round-robin arbiter, in-order command FIFO and delay
// sequencer that turns timed SET commands into one-cycle write strobes for
// the SET register bank.
module set_cmd_scheduler #(
  parameter  int REQ_NB     = 2,
  parameter  int SET_SIZE   = 5,
  parameter  int SET_WIDTH  = 32,
  parameter  int DLY_WIDTH  = 16,
  parameter  int FIFO_DEPTH = 4,
  localparam int IDX_W      = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [REQ_NB-1:0]                   i_req_valid,
  output logic [REQ_NB-1:0]                   o_req_ready,
  input  logic [REQ_NB-1:0][IDX_W-1:0]        i_req_idx,
  input  logic [REQ_NB-1:0][SET_WIDTH-1:0]    i_req_data,
  input  logic [REQ_NB-1:0][DLY_WIDTH-1:0]    i_req_dly,
  input  logic                                i_flush,
  output logic                                o_set_wr,
  output logic [IDX_W-1:0]                    o_set_idx,
  output logic [SET_WIDTH-1:0]                o_set_data,
  output logic [LVL_W-1:0]                    o_fifo_level,
  output logic                                o_busy,
  output logic                                o_err
);

  localparam int RR_W    = (REQ_NB > 1) ? $clog2(REQ_NB) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = IDX_W + SET_WIDTH + DLY_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  // Arbitration
  logic [RR_W-1:0]      rr_r;
  logic [RR_W-1:0]      gnt_idx_s;
  logic                 gnt_vld_s;
  logic [REQ_NB-1:0]    gnt_oh_s;
  logic                 accept_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic [SET_WIDTH-1:0] sel_data_s;
  logic [DLY_WIDTH-1:0] sel_dly_s;
  logic                 idx_ok_s;
  logic                 push_s;

  // FIFO
  logic [ENTRY_W-1:0]   fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [LVL_W-1:0]     level_r;
  logic                 full_s;
  logic                 empty_s;
  logic                 pop_s;
  logic [IDX_W-1:0]     head_idx_s;
  logic [SET_WIDTH-1:0] head_data_s;
  logic [DLY_WIDTH-1:0] head_dly_s;

  // Sequencer
  state_t               state_r;
  logic [DLY_WIDTH-1:0] cnt_r;
  logic [IDX_W-1:0]     wk_idx_r;
  logic [SET_WIDTH-1:0] wk_data_r;
  logic                 err_r;

  // Round-robin search: first valid source at or above the pointer, then wrap to the bottom.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    for (int j = 0; j < REQ_NB; j++) begin
      if (!gnt_vld_s && i_req_valid[j] && (j >= int'(rr_r))) begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = RR_W'(j);
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
    for (int j = 0; j < REQ_NB; j++) begin
      if (!gnt_vld_s && i_req_valid[j]) begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = RR_W'(j);
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
  end

  // One-hot view of the grant used to build the per-source ready vector.
  always_comb begin
    gnt_oh_s = '0;
    for (int j = 0; j < REQ_NB; j++) begin
      gnt_oh_s[j] = gnt_vld_s && (gnt_idx_s == RR_W'(j));
    end
  end

  assign full_s      = (level_r == LVL_W'(FIFO_DEPTH));
  assign empty_s     = (level_r == {LVL_W{1'b0}});
  // Ready looks only at the registered level, never at a same-cycle pop.
  assign o_req_ready = gnt_oh_s & {REQ_NB{~full_s & ~i_flush}};
  assign accept_s    = gnt_vld_s & ~full_s & ~i_flush;

  assign sel_idx_s   = i_req_idx[gnt_idx_s];
  assign sel_data_s  = i_req_data[gnt_idx_s];
  assign sel_dly_s   = i_req_dly[gnt_idx_s];
  // Extra MSB keeps the compare correct when SET_SIZE is a power of two.
  assign idx_ok_s    = ({1'b0, sel_idx_s} < (IDX_W + 1)'(SET_SIZE));
  assign push_s      = accept_s & idx_ok_s;

  assign pop_s       = (state_r == ST_IDLE) & ~empty_s & ~i_flush;
  assign {head_idx_s, head_data_s, head_dly_s} = fifo_mem_r[rd_ptr_r];

  assign o_fifo_level = level_r;
  assign o_busy       = ~empty_s | (state_r != ST_IDLE);
  assign o_err        = err_r;

  // Round-robin pointer advance on a transfer and sticky bad-index flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_r  <= '0;
      err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        rr_r <= (gnt_idx_s == RR_W'(REQ_NB - 1)) ? '0 : gnt_idx_s + RR_W'(1);
      end else begin
        rr_r <= rr_r;
      end
      if (accept_s && !idx_ok_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // Command FIFO storage, pointers and occupancy; flush empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifo_mem_r[k] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else if (i_flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {sel_idx_s, sel_data_s, sel_dly_s};
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Sequencer: pop head, count down its delay, then raise a one-cycle registered strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      wk_idx_r   <= '0;
      wk_data_r  <= '0;
      o_set_wr   <= 1'b0;
      o_set_idx  <= '0;
      o_set_data <= '0;
    end else if (i_flush) begin
      // idx/data keep their last issued value; only the strobe and state clear.
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      o_set_wr <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          o_set_wr <= 1'b0;
          if (!empty_s) begin
            wk_idx_r  <= head_idx_s;
            wk_data_r <= head_data_s;
            cnt_r     <= head_dly_s;
            if (head_dly_s == {DLY_WIDTH{1'b0}}) begin
              state_r    <= ST_ISSUE;
              o_set_wr   <= 1'b1;
              o_set_idx  <= head_idx_s;
              o_set_data <= head_data_s;
            end else begin
              state_r <= ST_WAIT;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // A zero count cannot occur here; treating it like 1 keeps the counter from wrapping.
          if (cnt_r <= DLY_WIDTH'(1)) begin
            state_r    <= ST_ISSUE;
            cnt_r      <= '0;
            o_set_wr   <= 1'b1;
            o_set_idx  <= wk_idx_r;
            o_set_data <= wk_data_r;
          end else begin
            cnt_r    <= cnt_r - DLY_WIDTH'(1);
            o_set_wr <= 1'b0;
          end
        end
        ST_ISSUE: begin
          state_r  <= ST_IDLE;
          o_set_wr <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          cnt_r    <= '0;
          o_set_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_cmd_scheduler.sv
// tb_set_cmd_scheduler: directed scenarios plus randomized traffic, checked
// against a transaction-level model (command queue + absolute issue times).
module tb_set_cmd_scheduler;

  localparam int REQ_NB     = 2;
  localparam int SET_SIZE   = 5;
  localparam int SET_WIDTH  = 32;
  localparam int DLY_WIDTH  = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int IDX_W      = 3;
  localparam int LVL_W      = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [REQ_NB-1:0]                req_valid;
  logic [REQ_NB-1:0]                req_ready;
  logic [REQ_NB-1:0][IDX_W-1:0]     req_idx;
  logic [REQ_NB-1:0][SET_WIDTH-1:0] req_data;
  logic [REQ_NB-1:0][DLY_WIDTH-1:0] req_dly;
  logic                             flush;
  logic                             set_wr;
  logic [IDX_W-1:0]                 set_idx;
  logic [SET_WIDTH-1:0]             set_data;
  logic [LVL_W-1:0]                 fifo_level;
  logic                             busy;
  logic                             err;

  set_cmd_scheduler #(
    .REQ_NB(REQ_NB), .SET_SIZE(SET_SIZE), .SET_WIDTH(SET_WIDTH),
    .DLY_WIDTH(DLY_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_idx(req_idx), .i_req_data(req_data), .i_req_dly(req_dly),
    .i_flush(flush),
    .o_set_wr(set_wr), .o_set_idx(set_idx), .o_set_data(set_data),
    .o_fifo_level(fifo_level), .o_busy(busy), .o_err(err)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          dly;
  } cmd_t;

  // Reference model: a queue of accepted commands, the command being
  // serviced and the absolute edge number at which its strobe registers.
  cmd_t        q[$];
  bit          have_cur;
  cmd_t        cur;
  int          issue_edge;
  int          edge_n;
  bit          m_wr;
  logic [2:0]  m_idx;
  logic [31:0] m_data;
  bit          m_err;
  int          rr;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant();
    for (int i = 0; i < REQ_NB; i++) begin
      int c = (rr + i) % REQ_NB;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    have_cur = 1'b0;
    m_wr     = 1'b0;
    m_idx    = '0;
    m_data   = '0;
    m_err    = 1'b0;
    rr       = 0;
  endtask

  task automatic check_outs();
    check_val("set_wr",   set_wr,     m_wr);
    check_val("set_idx",  set_idx,    m_idx);
    check_val("set_data", set_data,   m_data);
    check_val("level",    fifo_level, q.size());
    check_val("busy",     busy,       (q.size() != 0) || have_cur);
    check_val("err",      err,        m_err);
  endtask

  task automatic set_src(input int s, input bit v, input int idx, input logic [31:0] d, input int dl);
    req_valid[s] = v;
    req_idx[s]   = IDX_W'(idx);
    req_data[s]  = d;
    req_dly[s]   = DLY_WIDTH'(dl);
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    flush     = 1'b0;
  endtask

  // One clock: check combinational ready, advance the model at the edge,
  // then check registered outputs on the falling edge.
  task automatic cycle();
    int                g;
    logic [REQ_NB-1:0] exp_ready;
    bit                idle_pre;
    cmd_t              c;
    #1;
    g = model_grant();
    exp_ready = '0;
    if (g >= 0 && q.size() < FIFO_DEPTH && !flush) exp_ready[g] = 1'b1;
    check_val("ready", req_ready, exp_ready);
    @(posedge clk);
    edge_n++;
    if (flush) begin
      q.delete();
      have_cur = 1'b0;
      m_wr     = 1'b0;
    end else begin
      idle_pre = !have_cur;
      if (have_cur && edge_n == issue_edge + 1) begin
        have_cur = 1'b0;
      end else if (idle_pre && q.size() > 0) begin
        cur        = q.pop_front();
        have_cur   = 1'b1;
        issue_edge = edge_n + cur.dly;
      end
      m_wr = have_cur && (edge_n == issue_edge);
      if (m_wr) begin
        m_idx  = cur.idx[2:0];
        m_data = cur.data;
      end
      if (exp_ready != '0) begin
        if (int'(req_idx[g]) < SET_SIZE) begin
          c.idx  = int'(req_idx[g]);
          c.data = req_data[g];
          c.dly  = int'(req_dly[g]);
          q.push_back(c);
        end else begin
          m_err = 1'b1;
        end
        rr = (g + 1) % REQ_NB;
      end
    end
    @(negedge clk);
    check_outs();
  endtask

  task automatic run_idle(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    req_valid = '0;
    req_idx   = '0;
    req_data  = '0;
    req_dly   = '0;
    flush     = 1'b0;
    edge_n    = 0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_outs();
    check_val("ready_rst", req_ready, 2'b00);
    rst_n = 1'b1;

    // Single command, zero delay
    set_src(0, 1'b1, 2, 32'hDEADBEEF, 0);
    cycle();
    run_idle(6);

    // Long delay
    set_src(0, 1'b1, 4, 32'h7, 10);
    cycle();
    run_idle(15);

    // Both sources continuously valid, queue fills up
    for (int i = 0; i < 14; i++) begin
      set_src(0, 1'b1, 1, 32'hA000_0000 + i, 2);
      set_src(1, 1'b1, 3, 32'hB000_0000 + i, 2);
      cycle();
    end
    run_idle(30);

    // Out-of-range index then a normal command
    set_src(1, 1'b1, 5, 32'h55, 0);
    cycle();
    idle_inputs();
    set_src(0, 1'b1, 1, 32'h1234, 1);
    cycle();
    run_idle(6);

    // Flush during WAIT
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      set_src(0, 1'b1, i, 32'hF00 + i, 100);
      cycle();
    end
    run_idle(10);
    flush = 1'b1;
    cycle();
    run_idle(120);

    // Asynchronous reset mid-WAIT
    set_src(0, 1'b1, 3, 32'hCAFE, 100);
    cycle();
    run_idle(5);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_src(0, 1'b1, 0, 32'h11, 0);
    set_src(1, 1'b1, 1, 32'h22, 0);
    for (int i = 0; i < 3; i++) cycle();
    run_idle(10);

    // Randomized traffic
    for (int n = 0; n < 2500; n++) begin
      for (int s = 0; s < REQ_NB; s++) begin
        set_src(s, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 5)), $urandom(),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3)));
      end
      flush = ($urandom_range(0, 39) == 0);
      cycle();
    end
    run_idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/set_cmd_scheduler.md
Name: set_cmd_scheduler

Overview:
- Sequencer and arbiter in front of the SET register bank.
- Accepts timed SET commands (register index, value, delay) from REQ_NB scenario sources through valid/ready handshakes.
- Arbitrates between sources round-robin, queues accepted commands in a FIFO, and replays them in order.
- Each command waits its programmed delay, then is issued as a one-cycle write strobe with index and data to the SET bank.

Parameters:
- REQ_NB, 2, number of requesting sources.
- SET_SIZE, 5, number of SET registers; valid index range 0..SET_SIZE-1.
- SET_WIDTH, 32, width of each SET value.
- DLY_WIDTH, 16, width of the per-command delay field.
- FIFO_DEPTH, 4, command queue depth (power of 2, >= 2).
- Derived: IDX_W = $clog2(SET_SIZE) (min 1); LVL_W = $clog2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  REQ_NB  per-source command valid.
- o_req_ready  out  REQ_NB  per-source ready; at most one bit high.
- i_req_idx  in  REQ_NB x IDX_W  per-source target register index.
- i_req_data  in  REQ_NB x SET_WIDTH  per-source value.
- i_req_dly  in  REQ_NB x DLY_WIDTH  per-source delay in cycles.
- i_flush  in  1  synchronous flush of the queue and any pending command.
- o_set_wr  out  1  one-cycle write strobe to the SET bank.
- o_set_idx  out  IDX_W  index qualified by o_set_wr.
- o_set_data  out  SET_WIDTH  value qualified by o_set_wr.
- o_fifo_level  out  LVL_W  number of queued commands.
- o_busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.
- o_err  out  1  sticky flag: out-of-range index was received.

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0; FIFO empty; FSM in IDLE; round-robin pointer = 0; delay counter 0.
  - Reset mid-WAIT or mid-ISSUE aborts immediately; nothing is issued.
- Arbitration (combinational):
  - Grant goes to the first source with valid high, searching from the rr pointer upward with wrap.
  - o_req_ready[g] = grant[g] & ~full & ~i_flush.
  - A transfer occurs on an edge where valid & ready.
  - On transfer, the pointer becomes (g+1) mod REQ_NB; otherwise the pointer holds.
  - At most one acceptance per cycle.
  - ready never depends on same-cycle pop: when full, nothing is accepted even if a pop occurs that edge.
- Index check:
  - An accepted command with idx >= SET_SIZE completes its handshake but is not queued.
  - o_err is set on that edge and stays high until reset.
- FIFO: in-order; level = pushes - pops; full when level == FIFO_DEPTH.
- FSM states: IDLE, WAIT, ISSUE.
  - IDLE: if FIFO non-empty, pop the head into working registers (idx, data) and load counter = dly.
    - If dly == 0, go to ISSUE; else go to WAIT.
  - WAIT: decrement the counter each edge. When the counter == 1 at an edge, go to ISSUE. Total WAIT residency = dly cycles.
  - ISSUE: o_set_wr = 1 for exactly one cycle, with o_set_idx/o_set_data = working registers. Next edge returns to IDLE.
- Output registering:
  - o_set_wr, o_set_idx and o_set_data are registered.
  - o_set_idx/o_set_data hold their last issued value when o_set_wr = 0.
- Latency:
  - Command accepted at edge E0 is popped at E1; o_set_wr is high in the cycle after edge E(1+dly).
  - Back-to-back dly=0 commands issue one strobe every 2 cycles.
- Flush (i_flush high at an edge):
  - FIFO emptied; FSM goes to IDLE; counter cleared; o_set_wr = 0 next cycle; no acceptance that cycle.
  - If flush coincides with an ISSUE cycle, that strobe (already visible) completes; nothing further issues.
  - o_err is unaffected.
- Delay counter never wraps; the maximum delay is 2^DLY_WIDTH-1 cycles.

Test Plan:
- Single source, idx=2, data=0xDEADBEEF, dly=0, accepted at edge E0 -> o_set_wr high for exactly one cycle after E1, with o_set_idx=2 and o_set_data=0xDEADBEEF; o_busy returns to 0 afterwards.
- idx=4, data=7, dly=10 -> strobe appears after edge E11; o_busy stays high throughout the wait; no strobe before.
- Both sources hold valid continuously with distinct data, pointer=0 -> acceptance alternates src0, src1, src0…; once 4 are queued, both readies are low until the first pop; issue order matches acceptance order.
- idx=5 with SET_SIZE=5 -> handshake completes, o_err rises and stays high, no o_set_wr, o_fifo_level unchanged; a following valid command still issues normally.
- Queue 3 commands with dly=100, assert i_flush during WAIT -> o_fifo_level=0 next cycle, FSM in IDLE, no strobes ever issued; o_err unchanged.
- rst_n pulsed low asynchronously mid-WAIT (no clock edge) -> all outputs 0 immediately; after release, new commands are accepted starting from source 0.
